// File: rtl/ep_port_pkg.sv
// Shared constants and helpers for the external-port responder.
package ep_port_pkg;

  localparam int EP_WIDTH         = 16;
  localparam int EP_DEPTH_DEFAULT = 8;

  // Number of bits needed to index 'depth' entries (depth >= 2).
  function automatic int clog2_depth(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/ep_sync_fifo.sv
// Single-clock FIFO with guarded push/pop; same-cycle push and pop allowed when not full.
module ep_sync_fifo
  import ep_port_pkg::*;
#(
  parameter int WIDTH = EP_WIDTH,
  parameter int DEPTH = EP_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             r,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = clog2_depth(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  // Fullness and emptiness come from the registered count, i.e. before the edge.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (r) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ep_port_responder.sv
// Peripheral-side responder for one CPU external port: TX/RX FIFOs behind the we/oe strobes.
module ep_port_responder
  import ep_port_pkg::*;
#(
  parameter int DEPTH = EP_DEPTH_DEFAULT,
  parameter int WIDTH = EP_WIDTH
) (
  input  logic             clk,
  input  logic             r,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             we,
  input  logic             oe,
  output logic [WIDTH-1:0] dev_tx_data,
  output logic             dev_tx_valid,
  input  logic             dev_tx_ready,
  input  logic [WIDTH-1:0] dev_rx_data,
  input  logic             dev_rx_valid,
  output logic             dev_rx_ready,
  output logic             tx_full,
  output logic             rx_empty,
  output logic             overflow,
  output logic             underflow
);

  logic             we_q, we_d;
  logic             oe_q, oe_d;
  logic             rd_empty_q, rd_empty_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             we_rise, oe_rise, oe_fall;
  logic             tx_push, tx_pop, tx_empty;
  logic             rx_push, rx_pop, rx_full;
  logic             rd_sel_empty;
  logic [WIDTH-1:0] rx_head, rd_value;

  assign we_rise = we & ~we_q;
  assign oe_rise = oe & ~oe_q;
  assign oe_fall = ~oe & oe_q;

  // A write into a full TX is dropped even if the device pops in the same cycle.
  assign tx_push = we_rise & ~tx_full;
  assign tx_pop  = dev_tx_valid & dev_tx_ready;
  assign rx_push = dev_rx_valid & dev_rx_ready;
  // The RX head is consumed only when the read ends, so it is stable while oe is high.
  assign rx_pop  = oe_fall & ~rd_empty_q;

  ep_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .r         (r),
    .push      (tx_push),
    .push_data (bus),
    .pop       (tx_pop),
    .head      (dev_tx_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  ep_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .r         (r),
    .push      (rx_push),
    .push_data (dev_rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign dev_tx_valid = ~tx_empty;
  assign dev_rx_ready = ~rx_full;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Emptiness is latched at the start of a read so a mid-read device push cannot change the bus.
  assign rd_sel_empty = oe_rise ? rx_empty : rd_empty_q;
  assign rd_value     = rd_sel_empty ? '0 : rx_head;
  assign bus          = (oe & ~r) ? rd_value : {WIDTH{1'bz}};

  // Next-state for strobe history, read-empty latch and sticky error flags.
  always_comb begin
    we_d        = we;
    oe_d        = oe;
    rd_empty_d  = oe_rise ? rx_empty : rd_empty_q;
    overflow_d  = overflow_q | (we_rise & tx_full);
    underflow_d = underflow_q | (oe_fall & rd_empty_q);
  end

  // Control registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (r) begin
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      rd_empty_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      we_q        <= we_d;
      oe_q        <= oe_d;
      rd_empty_q  <= rd_empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_ep_port_responder.sv
// Scoreboard bench for ep_port_responder: directed CPU/device traffic, queued expectations.
module tb_ep_port_responder;

  logic        clk = 1'b0;
  logic        r;
  logic        we, oe;
  logic        dev_tx_ready, dev_rx_valid;
  logic [15:0] dev_rx_data;
  logic [15:0] dev_tx_data;
  logic        dev_tx_valid, dev_rx_ready, tx_full, rx_empty, overflow, underflow;
  logic        tb_drv_en;
  logic [15:0] tb_drv_val;

  // Bus is pulled high so an undriven bus reads as 16'hFFFF.
  tri1 [15:0] bus;
  assign bus = tb_drv_en ? tb_drv_val : 16'hzzzz;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_tx [$];
  logic [15:0] exp_rd [$];

  always #5 clk = ~clk;

  ep_port_responder #(.DEPTH(8), .WIDTH(16)) dut (
    .clk          (clk),
    .r            (r),
    .bus          (bus),
    .we           (we),
    .oe           (oe),
    .dev_tx_data  (dev_tx_data),
    .dev_tx_valid (dev_tx_valid),
    .dev_tx_ready (dev_tx_ready),
    .dev_rx_data  (dev_rx_data),
    .dev_rx_valid (dev_rx_valid),
    .dev_rx_ready (dev_rx_ready),
    .tx_full      (tx_full),
    .rx_empty     (rx_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // TX monitor: each accepted handshake must match the next queued word.
  always @(negedge clk) begin
    if (!r && dev_tx_valid && dev_tx_ready) begin
      if (exp_tx.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected: got %h want none", dev_tx_data);
      end else begin
        chk("tx_data", {16'h0, dev_tx_data}, {16'h0, exp_tx.pop_front()});
      end
    end
  end

  // Bus monitor: every cycle with oe high must present the next queued read value.
  always @(negedge clk) begin
    if (!r && oe) begin
      if (exp_rd.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got %h want none", bus);
      end else begin
        chk("rd_bus", {16'h0, bus}, {16'h0, exp_rd.pop_front()});
      end
    end
  end

  task automatic cpu_write(input logic [15:0] v);
    @(posedge clk); #1;
    tb_drv_val = v; tb_drv_en = 1'b1; we = 1'b1;
    repeat (3) @(posedge clk);
    #1; we = 1'b0; tb_drv_en = 1'b0;
  endtask

  task automatic cpu_read(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) exp_rd.push_back(v);
    @(posedge clk); #1; oe = 1'b1;
    repeat (n) @(posedge clk);
    #1; oe = 1'b0;
  endtask

  task automatic dev_push(input logic [15:0] v);
    @(posedge clk); #1; dev_rx_valid = 1'b1; dev_rx_data = v;
    @(posedge clk); #1; dev_rx_valid = 1'b0;
  endtask

  task automatic wait_tx_drain(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!dev_tx_valid) done = 1'b1;
    end
    chk(nm, {31'h0, done}, 32'h1);
    @(posedge clk); #1; dev_tx_ready = 1'b0;
  endtask

  task automatic wait_rx_ready(input string nm, input logic lvl);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (dev_rx_ready == lvl) done = 1'b1;
    end
    chk(nm, {31'h0, done}, 32'h1);
  endtask

  initial begin
    r = 1'b1; we = 1'b0; oe = 1'b1;
    dev_tx_ready = 1'b0; dev_rx_valid = 1'b0; dev_rx_data = 16'h0;
    tb_drv_en = 1'b0; tb_drv_val = 16'h0;

    // Reset with oe high: bus must stay undriven (pulled high).
    repeat (3) @(negedge clk);
    chk("rst_bus_z",     {16'h0, bus}, 32'h0000_FFFF);
    chk("rst_rx_empty",  {31'h0, rx_empty}, 32'h1);
    chk("rst_rx_ready",  {31'h0, dev_rx_ready}, 32'h1);
    chk("rst_tx_valid",  {31'h0, dev_tx_valid}, 32'h0);
    chk("rst_tx_full",   {31'h0, tx_full}, 32'h0);
    chk("rst_overflow",  {31'h0, overflow}, 32'h0);
    chk("rst_underflow", {31'h0, underflow}, 32'h0);
    @(posedge clk); #1; oe = 1'b0; r = 1'b0;

    // Two held writes, one-cycle write-to-valid latency, then drain in order.
    @(posedge clk); #1;
    tb_drv_val = 16'hA001; tb_drv_en = 1'b1; we = 1'b1;
    @(negedge clk);
    chk("wr_lat_before", {31'h0, dev_tx_valid}, 32'h0);
    @(negedge clk);
    chk("wr_lat_after", {31'h0, dev_tx_valid}, 32'h1);
    chk("wr_head", {16'h0, dev_tx_data}, 32'h0000_A001);
    repeat (2) @(posedge clk);
    #1; we = 1'b0; tb_drv_en = 1'b0;
    cpu_write(16'hA002);
    @(negedge clk);
    chk("wr2_not_full", {31'h0, tx_full}, 32'h0);
    chk("wr2_head", {16'h0, dev_tx_data}, 32'h0000_A001);
    exp_tx.push_back(16'hA001);
    exp_tx.push_back(16'hA002);
    @(posedge clk); #1; dev_tx_ready = 1'b1;
    wait_tx_drain("tx_drain1");
    chk("tx_q1_empty", exp_tx.size(), 32'h0);

    // Fill TX, overflow on the 9th, and a write into full while popping is dropped.
    for (int i = 1; i <= 9; i++) begin
      cpu_write(16'hB000 + 16'(i));
      @(negedge clk);
      if (i == 8) begin
        chk("tx_full_at8", {31'h0, tx_full}, 32'h1);
        chk("ovf_clear_at8", {31'h0, overflow}, 32'h0);
      end
    end
    chk("tx_full_at9", {31'h0, tx_full}, 32'h1);
    chk("ovf_set", {31'h0, overflow}, 32'h1);
    for (int i = 1; i <= 8; i++) exp_tx.push_back(16'hB000 + 16'(i));
    @(posedge clk); #1;
    tb_drv_val = 16'hB0FF; tb_drv_en = 1'b1; we = 1'b1; dev_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1; we = 1'b0; tb_drv_en = 1'b0;
    wait_tx_drain("tx_drain2");
    chk("tx_q2_empty", exp_tx.size(), 32'h0);
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);

    // Device word, then a 4-cycle read; pop happens on oe fall.
    dev_push(16'h1234);
    @(negedge clk);
    chk("rx_lat_nonempty", {31'h0, rx_empty}, 32'h0);
    cpu_read(4, 16'h1234);
    @(negedge clk);
    chk("rx_hold_until_fall", {31'h0, rx_empty}, 32'h0);
    @(negedge clk);
    chk("rx_empty_after_pop", {31'h0, rx_empty}, 32'h1);
    chk("unf_clear", {31'h0, underflow}, 32'h0);

    // Empty read with a device push mid-read: bus stays 0, underflow set.
    fork
      cpu_read(4, 16'h0000);
      begin
        repeat (2) @(posedge clk);
        #1; dev_rx_valid = 1'b1; dev_rx_data = 16'h5555;
        @(posedge clk); #1; dev_rx_valid = 1'b0;
      end
    join
    @(negedge clk);
    chk("unf_before_fall", {31'h0, underflow}, 32'h0);
    @(negedge clk);
    chk("unf_set", {31'h0, underflow}, 32'h1);
    chk("rx_kept_5555", {31'h0, rx_empty}, 32'h0);
    cpu_read(2, 16'h5555);
    repeat (2) @(negedge clk);
    chk("rx_empty_after_5555", {31'h0, rx_empty}, 32'h1);

    // Fill RX across the pointer wrap, refill during a read, drain in order.
    @(posedge clk); #1; dev_rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dev_rx_data = 16'hC000 + 16'(i);
      @(posedge clk); #1;
    end
    dev_rx_data = 16'hC008;
    @(negedge clk);
    chk("rx_full_ready", {31'h0, dev_rx_ready}, 32'h0);
    cpu_read(2, 16'hC000);
    wait_rx_ready("rx_ready_after_pop", 1'b1);
    wait_rx_ready("rx_refull", 1'b0);
    @(posedge clk); #1; dev_rx_valid = 1'b0;
    for (int i = 1; i <= 8; i++) cpu_read(1, 16'hC000 + 16'(i));
    repeat (2) @(negedge clk);
    chk("rx_empty_end", {31'h0, rx_empty}, 32'h1);
    chk("unf_sticky", {31'h0, underflow}, 32'h1);
    chk("rd_q_empty", exp_rd.size(), 32'h0);
    chk("tx_q_empty_end", exp_tx.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
